core_sequencer: RTL and testbench

//  Multi-cycle sequencer for the single-issue 16-bit core: fetches each instruction from

---
 rtl/core_sequencer_pkg.sv | 26 ++
 rtl/core_sequencer_timeout.sv | 26 ++
 rtl/core_sequencer.sv | 122 ++++++++++++
 tb/tb_core_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared core definitions: sequencer state encoding, opcode map and the
// flag-setting opcode predicate (the decoder uses the same opcode values).
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDZ = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_HLT  = 4'hF;

    function automatic logic is_flag_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDZ) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_NOR);
    endfunction

endpackage

// File: rtl/core_sequencer_timeout.sv
// Fetch wait counter: counts cycles spent waiting for instruction memory and
// flags the last permitted cycle. LIMIT of 0 disables expiry.
module fetch_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

    assign expired = (LIMIT != 0) && (cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH->DECODE->EXEC->WB sequencer for the 16-bit core: owns the
// PC, instruction register, Z flag, retire counter and halt/fetch-error status.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FETCH_TO = 15,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instr,
    output logic              zr,
    input  logic              dec_hlt,
    input  logic              dec_we,
    input  logic              dec_re0,
    input  logic              dec_re1,
    input  logic              alu_zr,
    output logic              rf_re0,
    output logic              rf_re1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  retired
);
    seq_state_t state, state_nxt;
    logic       to_expired;

    // Counter is held clear outside FETCH, so every FETCH entry starts at zero.
    fetch_timeout_ctr #(.LIMIT(FETCH_TO)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != ST_FETCH),
        .en      ((state == ST_FETCH) && !imem_rdy),
        .expired (to_expired)
    );

    assign imem_addr = pc;

    always_comb begin
        state_nxt  = state;
        imem_rd_en = 1'b0;
        rf_re0     = 1'b0;
        rf_re1     = 1'b0;
        rf_we      = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_rd_en = 1'b1;
                if (imem_rdy)
                    state_nxt = ST_DECODE;
                else if (to_expired)
                    state_nxt = ST_HALT;
            end
            ST_DECODE: begin
                if (dec_hlt) begin
                    state_nxt = ST_HALT;
                end else begin
                    rf_re0    = dec_re0;
                    rf_re1    = dec_re1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rf_re0    = dec_re0;
                rf_re1    = dec_re1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                rf_we     = dec_we;
                state_nxt = ST_FETCH;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_FETCH;
        endcase
        if (!rst_n) begin
            imem_rd_en = 1'b0;
            rf_re0     = 1'b0;
            rf_re1     = 1'b0;
            rf_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            instr     <= 16'h0000;
            zr        <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_FETCH: begin
                    if (imem_rdy) begin
                        instr <= imem_data;
                    end else if (to_expired) begin
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                    end
                end
                ST_DECODE: if (dec_hlt) halted <= 1'b1;
                // Z updates at WB so an addz's dec_we stays stable through its own WB.
                ST_WB: begin
                    pc      <= pc + ADDR_W'(1);
                    retired <= retired + CNT_W'(1);
                    if (is_flag_op(instr[15:12]))
                        zr <= alu_zr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: behavioural decoder and instruction
// memory with programmable ready delay; a second instance covers PC wrap.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        imem_rd_en, imem_rdy, zr, dec_hlt, dec_we, dec_re0, dec_re1;
    logic        alu_zr, rf_re0, rf_re1, rf_we, halted, fetch_err;
    logic [15:0] imem_addr, imem_data, instr, pc, retired;

    logic        imem_rd_en2, zr2, rf_re02, rf_re12, rf_we2, halted2, fetch_err2;
    logic [15:0] imem_addr2, instr2, pc2, retired2;
    logic        one = 1'b1;
    logic        zero = 1'b0;
    logic [15:0] nop_word = 16'h0000;

    logic [15:0] mem [16];
    int          rdy_delay = 0;
    bit          rdy_stuck = 1'b0;
    int          fetch_wait = 0;

    int errors = 0;
    int checks = 0;

    core_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .FETCH_TO(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .instr(instr), .zr(zr),
        .dec_hlt(dec_hlt), .dec_we(dec_we), .dec_re0(dec_re0), .dec_re1(dec_re1),
        .alu_zr(alu_zr), .rf_re0(rf_re0), .rf_re1(rf_re1), .rf_we(rf_we), .pc(pc),
        .halted(halted), .fetch_err(fetch_err), .retired(retired)
    );

    // Always-ready memory full of nops, started at the top of the address space.
    core_sequencer #(.ADDR_W(16), .RESET_PC(16'hFFFF), .FETCH_TO(15), .CNT_W(16)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_rd_en(imem_rd_en2), .imem_addr(imem_addr2),
        .imem_rdy(one), .imem_data(nop_word), .instr(instr2), .zr(zr2),
        .dec_hlt(zero), .dec_we(zero), .dec_re0(zero), .dec_re1(zero),
        .alu_zr(zero), .rf_re0(rf_re02), .rf_re1(rf_re12), .rf_we(rf_we2), .pc(pc2),
        .halted(halted2), .fetch_err(fetch_err2), .retired(retired2)
    );

    assign imem_data = mem[imem_addr[3:0]];
    assign imem_rdy  = imem_rd_en && !rdy_stuck && (fetch_wait >= rdy_delay);

    always @(posedge clk) begin
        if (!rst_n || !imem_rd_en || imem_rdy) fetch_wait <= 0;
        else                                   fetch_wait <= fetch_wait + 1;
    end

    logic [3:0] op;
    always_comb begin
        op      = instr[15:12];
        dec_hlt = (op == OP_HLT);
        dec_we  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_NOR) ||
                  ((op == OP_ADDZ) && zr);
        dec_re0 = !((op == OP_NOP) || (op == OP_HLT));
        dec_re1 = dec_re0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench 1 unit after a negedge with rst_n just released (cycle 1).
    task automatic do_reset(input bit chk_rst);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        if (chk_rst) begin
            chk("rst_pc", pc, 16'h0000);
            chk("rst_instr", instr, 16'h0000);
            chk("rst_zr", zr, 0);
            chk("rst_halted", halted, 0);
            chk("rst_fetch_err", fetch_err, 0);
            chk("rst_retired", retired, 0);
            chk("rst_enables", {imem_rd_en, rf_re0, rf_re1, rf_we}, 0);
            chk("rst_wrap_pc", pc2, 16'hFFFF);
        end
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic        alu_z;
        logic        rd_en;
        logic        re0;
        logic        we;
        logic        hlt;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl[12];
    int   cyc;
    int   bad;
    logic [15:0] start_pc;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
        alu_zr = 1'b0;

        // add, sub, hlt with zero-wait memory
        foreach (mem[i]) mem[i] = {OP_NOP, 12'h000};
        mem[0] = {OP_ADD, 12'h123};
        mem[1] = {OP_SUB, 12'h456};
        mem[2] = {OP_HLT, 12'h000};
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            alu_zr = tbl[i].alu_z;
            chk($sformatf("t1_rd_en[%0d]", i), imem_rd_en, tbl[i].rd_en);
            chk($sformatf("t1_re0[%0d]", i), rf_re0, tbl[i].re0);
            chk($sformatf("t1_we[%0d]", i), rf_we, tbl[i].we);
            chk($sformatf("t1_halted[%0d]", i), halted, tbl[i].hlt);
            chk($sformatf("t1_pc[%0d]", i), pc, tbl[i].pc);
            step();
        end
        chk("t1_retired", retired, 2);
        chk("t1_fetch_err", fetch_err, 0);

        // 3-cycle ready delay: 7 cycles per instruction, address held while waiting
        mem[0] = {OP_ADD, 12'h000};
        mem[1] = {OP_ADD, 12'h000};
        mem[2] = {OP_HLT, 12'h000};
        rdy_delay = 3;
        do_reset(1'b0);
        bad = 0;
        for (int k = 0; k < 2; k++) begin
            cyc = 0;
            start_pc = pc;
            while (pc == start_pc && cyc < 50) begin
                if (imem_rd_en && imem_addr != start_pc) bad++;
                cyc++;
                step();
            end
            chk($sformatf("t2_cycles[%0d]", k), cyc, 7);
        end
        chk("t2_addr_stable", bad, 0);
        rdy_delay = 0;

        // sub giving zero, then addz writes back
        mem[0] = {OP_SUB, 12'h000};
        mem[1] = {OP_ADDZ, 12'h000};
        mem[2] = {OP_HLT, 12'h000};
        for (int r = 0; r < 2; r++) begin
            alu_zr = (r == 0);
            do_reset(1'b0);
            repeat (5) step();
            chk($sformatf("t3_zr_at_decode[%0d]", r), zr, (r == 0));
            repeat (2) step();
            chk($sformatf("t3_we_at_wb[%0d]", r), rf_we, (r == 0));
            step();
            chk($sformatf("t3_pc[%0d]", r), pc, 2);
        end
        alu_zr = 1'b0;

        // imem never ready: timeout after 15 fetch cycles
        rdy_stuck = 1'b1;
        do_reset(1'b0);
        cyc = 0;
        bad = 0;
        while (!halted && bad < 100) begin
            if (imem_rd_en) cyc++;
            bad++;
            step();
        end
        chk("t4_fetch_cycles", cyc, 15);
        chk("t4_fetch_err", fetch_err, 1);
        chk("t4_halted", halted, 1);
        chk("t4_pc", pc, 0);
        chk("t4_rd_en", imem_rd_en, 0);
        rdy_stuck = 1'b0;
        repeat (3) step();
        chk("t4_still_halted", {halted, fetch_err, imem_rd_en}, 3'b110);

        // pc wrap on the 16'hFFFF instance
        do_reset(1'b0);
        chk("t5_pc_start", pc2, 16'hFFFF);
        repeat (4) step();
        chk("t5_pc_wrapped", pc2, 16'h0000);
        chk("t5_retired", retired2, 1);

        // reset asserted in EXEC of the second instruction
        mem[0] = {OP_ADD, 12'h000};
        mem[1] = {OP_ADD, 12'h000};
        do_reset(1'b0);
        repeat (6) step();
        chk("t6_state_exec", dut.state, ST_EXEC);
        chk("t6_pc_before", pc, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_we_in_reset", rf_we, 0);
        step();
        chk("t6_state_fetch", dut.state, ST_FETCH);
        chk("t6_pc_reset", pc, 0);
        chk("t6_instr_reset", instr, 0);
        chk("t6_enables", {imem_rd_en, rf_we}, 0);
        rst_n = 1'b1;
        #1;
        chk("t6_rd_en_after", imem_rd_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
